updn_counter_mc: RTL and testbench
==================================

Name: updn_counter_mc

Overview:
Multi-channel, parametrised up/down counter bank. It is the successor to the single 16-bit up/down counter. Each channel has its own load, enable and direction controls. All channels share a programmable upper bound, step size and wrap/saturate mode. Per-channel boundary flags are provided for the interrupt/status logic downstream.

Parameters:
WIDTH, 16, counter width per channel (2..32)
CHANNELS, 4, number of independent counters (1..16)
STEP_W, 4, width of shared step input

Ports:
clk  input  1  clock, all state on posedge
rst_  input  1  asynchronous active-low reset
ld_cnt  input  CHANNELS  per channel, active-low synchronous load of data_in slice
count_enb  input  CHANNELS  per channel count enable
updn_cnt  input  CHANNELS  per channel direction, 1=up, 0=down
sat_mode  input  1  0=wrap, 1=saturate (shared)
cnt_max  input  WIDTH  inclusive upper bound; legal range 0..cnt_max
step  input  STEP_W  increment/decrement amount
data_in  input  CHANNELS*WIDTH  load values, channel i at [i*WIDTH +: WIDTH]
ovf_clr  input  CHANNELS  per channel clear of sticky ovf
data_out  output  CHANNELS*WIDTH  registered counts
tc  output  CHANNELS  one-cycle pulse, channel reached/crossed a bound this cycle
ovf  output  CHANNELS  sticky, set on any wrap or saturation event

Behaviour:
- Reset (rst_ low, async): data_out=0, tc=0, ovf=0 for every channel. Counting resumes on the first posedge after rst_ rises.
- Priority per channel each posedge: ld_cnt==0 > count_enb==1 > hold.
- Load: next = min(data_in_i, cnt_max). tc=0. ovf unchanged.
- Hold (ld_cnt=1, count_enb=0): data_out stable, tc=0.
- Count with step==0: hold, tc=0, no ovf.
- Up, wrap mode:
  - next = (cur+step) mod (cnt_max+1).
  - If cur+step > cnt_max: tc=1, ovf set.
  - Arithmetic uses WIDTH+1 bits, no intermediate overflow.
- Up, saturate mode:
  - next = min(cur+step, cnt_max).
  - tc=1 if next==cnt_max and cur!=cnt_max.
  - ovf set if cur+step > cnt_max.
- Down, wrap mode:
  - If cur >= step: next = cur-step.
  - Else: next = cnt_max+1-(step-cur). tc=1, ovf set.
- Down, saturate mode:
  - next = max(cur-step, 0).
  - tc=1 if next==0 and cur!=0.
  - ovf set if step > cur.
- Wrap with step > cnt_max+1: result is still the modular value (implementation may use repeated reduction or a divider-free compare chain). Step is bounded by STEP_W, so at most 2^STEP_W/(cnt_max+1) reductions.
- Exact hit in wrap mode (cur+step == cnt_max, up): next=cnt_max, tc=1, ovf unchanged. Same for down to 0.
- cnt_max changed below current value: on the next enabled count the channel first clamps to cnt_max, then applies the count. Holding channels keep their value until enabled or loaded.
- ovf_clr and ovf set in the same cycle: set wins.
- tc is registered, aligned with the data_out update. It is 0 whenever the channel does not count.
- Channels are fully independent. Simultaneous events on all channels must be handled in one cycle.
- Latency: one cycle from control sampling to data_out/tc update.
- Reset mid-count: immediate clear, no partial update.

Test Plan:
- Reset: rst_ low for 3 cycles mid-count -> all data_out=0, tc=0, ovf=0 immediately (async). Release, ch0 up step=1 -> 1 on the 1st posedge.
- Load priority: ch1 ld_cnt=0, count_enb=1, data_in=0x0123, cnt_max=0xFFFF -> data_out=0x0123. Then ld_cnt=1, count_enb=0 for 5 cycles -> stable 0x0123.
- Wrap up/down: cnt_max=9, step=3, ch2 loaded 8.
  - Up -> 1, tc=1, ovf=1.
  - Down from 1 -> 8, tc=1.
- Saturate: sat_mode=1, cnt_max=100, ch3 at 98, up step=5 -> 100, tc=1, ovf=1. Next up -> 100, tc=0. Down step=7 from 3 -> 0, tc=1.
- Independence: ch0 up, ch1 down, ch2 load, ch3 hold in one cycle, step=2, starting 5,5,x,5 -> 7, 3, data_in, 5.
- ovf_clr collision: ch0 wraps in the same cycle ovf_clr[0]=1 -> ovf[0]=1. Clear next cycle with no event -> ovf[0]=0.

Source files
------------

// File: rtl/updn_counter_mc.sv
// Multi-channel up/down counter bank with a shared bound, step and wrap/saturate mode.
// Each channel loads, counts or holds on its own and reports tc pulses and sticky ovf flags.
module updn_counter_mc #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int STEP_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst_,
    input  logic [CHANNELS-1:0]       ld_cnt,
    input  logic [CHANNELS-1:0]       count_enb,
    input  logic [CHANNELS-1:0]       updn_cnt,
    input  logic                      sat_mode,
    input  logic [WIDTH-1:0]          cnt_max,
    input  logic [STEP_W-1:0]         step,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [CHANNELS-1:0]       ovf_clr,
    output logic [CHANNELS*WIDTH-1:0] data_out,
    output logic [CHANNELS-1:0]       tc,
    output logic [CHANNELS-1:0]       ovf
);

    // Internal width holds any value+step sum and the modulus cnt_max+1 without overflow.
    localparam int AW     = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;
    localparam int RED_N  = 1 << STEP_W;

    logic [AW-1:0] max_x;
    logic [AW-1:0] mod_x;
    logic [AW-1:0] step_x;
    logic [AW-1:0] step_red;

    assign max_x  = AW'(cnt_max);
    assign mod_x  = max_x + AW'(1);
    assign step_x = AW'(step);

    // step mod (cnt_max+1), shared by every channel; a subtract chain avoids a divider.
    always_comb begin
        step_red = step_x;
        for (int k = 0; k < RED_N; k++) begin
            if (step_red >= mod_x) begin
                step_red = step_red - mod_x;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] cnt_reg;
            logic [WIDTH-1:0] cnt_next;
            logic             tc_reg;
            logic             tc_next;
            logic             ovf_reg;
            logic             ovf_set;
            logic [AW-1:0]    cur_x;
            logic [AW-1:0]    eff_x;
            logic [AW-1:0]    sum_x;
            logic [AW-1:0]    din_x;
            logic [AW-1:0]    res_x;

            always_comb begin
                cur_x   = AW'(cnt_reg);
                // A value left above a lowered bound is clamped before it counts.
                eff_x   = (cur_x > max_x) ? max_x : cur_x;
                sum_x   = eff_x + step_x;
                din_x   = AW'(data_in[gi*WIDTH +: WIDTH]);
                res_x   = cur_x;
                tc_next = 1'b0;
                ovf_set = 1'b0;

                if (!ld_cnt[gi]) begin
                    res_x = (din_x > max_x) ? max_x : din_x;
                end else if (count_enb[gi] && (step != '0)) begin
                    if (updn_cnt[gi]) begin
                        ovf_set = (sum_x > max_x);
                        if (sat_mode) begin
                            res_x   = ovf_set ? max_x : sum_x;
                            tc_next = (res_x == max_x) && (eff_x != max_x);
                        end else begin
                            res_x = eff_x + step_red;
                            if (res_x >= mod_x) begin
                                res_x = res_x - mod_x;
                            end
                            tc_next = (sum_x >= max_x);
                        end
                    end else begin
                        ovf_set = (step_x > eff_x);
                        if (sat_mode) begin
                            res_x   = ovf_set ? '0 : (eff_x - step_x);
                            tc_next = (res_x == '0) && (eff_x != '0);
                        end else if (!ovf_set) begin
                            res_x   = eff_x - step_x;
                            tc_next = (res_x == '0);
                        end else begin
                            // Underflow: wrap to the modular value below zero.
                            res_x   = (eff_x >= step_red) ? (eff_x - step_red)
                                                          : (eff_x + mod_x - step_red);
                            tc_next = 1'b1;
                        end
                    end
                end

                cnt_next = WIDTH'(res_x);
            end

            always_ff @(posedge clk or negedge rst_) begin
                if (!rst_) begin
                    cnt_reg <= '0;
                    tc_reg  <= 1'b0;
                    ovf_reg <= 1'b0;
                end else begin
                    cnt_reg <= cnt_next;
                    tc_reg  <= tc_next;
                    // A new event in the same cycle as a clear keeps the flag set.
                    ovf_reg <= ovf_set | (ovf_reg & ~ovf_clr[gi]);
                end
            end

            assign data_out[gi*WIDTH +: WIDTH] = cnt_reg;
            assign tc[gi]                      = tc_reg;
            assign ovf[gi]                     = ovf_reg;
        end
    endgenerate

endmodule

// File: tb/tb_updn_counter_mc.sv
// Directed plus randomized check of updn_counter_mc against a behavioural integer model.
// Expected results are queued at stimulus time and compared after the following posedge.
module tb_updn_counter_mc;

    localparam int W  = 16;
    localparam int CH = 4;
    localparam int SW = 4;

    logic            clk;
    logic            rst_;
    logic [CH-1:0]   ld_cnt;
    logic [CH-1:0]   count_enb;
    logic [CH-1:0]   updn_cnt;
    logic            sat_mode;
    logic [W-1:0]    cnt_max;
    logic [SW-1:0]   step;
    logic [CH*W-1:0] data_in;
    logic [CH-1:0]   ovf_clr;
    logic [CH*W-1:0] data_out;
    logic [CH-1:0]   tc;
    logic [CH-1:0]   ovf;

    updn_counter_mc #(.WIDTH(W), .CHANNELS(CH), .STEP_W(SW)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .ld_cnt    (ld_cnt),
        .count_enb (count_enb),
        .updn_cnt  (updn_cnt),
        .sat_mode  (sat_mode),
        .cnt_max   (cnt_max),
        .step      (step),
        .data_in   (data_in),
        .ovf_clr   (ovf_clr),
        .data_out  (data_out),
        .tc        (tc),
        .ovf       (ovf)
    );

    typedef struct {
        logic [CH*W-1:0] cnt;
        logic [CH-1:0]   tc;
        logic [CH-1:0]   ovf;
    } exp_t;

    exp_t          sb[$];
    logic [W-1:0]  m_cnt [CH];
    logic [CH-1:0] m_ovf;
    int            n_tests = 0;
    int            n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < CH; i++) m_cnt[i] = '0;
        m_ovf = '0;
    endtask

    // Integer model written straight from the behavioural description.
    task automatic predict(output exp_t e);
        int c, n, s, d, m, mx, st;
        bit t, o;
        mx = int'(cnt_max);
        st = int'(step);
        m  = mx + 1;
        for (int i = 0; i < CH; i++) begin
            c = int'(m_cnt[i]);
            n = c;
            t = 1'b0;
            o = 1'b0;
            if (!ld_cnt[i]) begin
                n = int'(data_in[i*W +: W]);
                if (n > mx) n = mx;
            end else if (count_enb[i] && st != 0) begin
                if (c > mx) c = mx;
                if (updn_cnt[i]) begin
                    s = c + st;
                    if (sat_mode) begin
                        n = (s > mx) ? mx : s;
                        t = (n == mx) && (c != mx);
                    end else begin
                        n = s % m;
                        t = (s >= mx);
                    end
                    o = (s > mx);
                end else begin
                    d = c - st;
                    if (sat_mode) begin
                        n = (d < 0) ? 0 : d;
                        t = (n == 0) && (c != 0);
                    end else begin
                        n = ((d % m) + m) % m;
                        t = (d <= 0);
                    end
                    o = (d < 0);
                end
            end
            m_cnt[i] = n[W-1:0];
            m_ovf[i] = o ? 1'b1 : (ovf_clr[i] ? 1'b0 : m_ovf[i]);
            e.tc[i]  = t;
        end
        for (int i = 0; i < CH; i++) e.cnt[i*W +: W] = m_cnt[i];
        e.ovf = m_ovf;
    endtask

    task automatic check(input string tag, input exp_t e);
        n_tests++;
        assert (data_out === e.cnt) else begin
            n_fail++;
            $error("FAIL %s data_out got %h want %h", tag, data_out, e.cnt);
        end
        n_tests++;
        assert (tc === e.tc) else begin
            n_fail++;
            $error("FAIL %s tc got %b want %b", tag, tc, e.tc);
        end
        n_tests++;
        assert (ovf === e.ovf) else begin
            n_fail++;
            $error("FAIL %s ovf got %b want %b", tag, ovf, e.ovf);
        end
        $display("[TB] %s: data_out=%h tc=%b ovf=%b", tag, data_out, tc, ovf);
    endtask

    task automatic cycle(input string tag);
        exp_t e;
        predict(e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(tag, e);
    endtask

    task automatic check_reset(input string tag);
        exp_t e;
        model_reset();
        e.cnt = '0;
        e.tc  = '0;
        e.ovf = '0;
        check(tag, e);
    endtask

    task automatic set_din(input int ch, input logic [W-1:0] v);
        data_in[ch*W +: W] = v;
    endtask

    task automatic idle();
        ld_cnt    = '1;
        count_enb = '0;
        ovf_clr   = '0;
    endtask

    initial begin
        rst_      = 1'b0;
        ld_cnt    = '1;
        count_enb = '0;
        updn_cnt  = '0;
        sat_mode  = 1'b0;
        cnt_max   = 16'hFFFF;
        step      = 4'd1;
        data_in   = '0;
        ovf_clr   = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_reset("reset_init");
        rst_ = 1'b1;

        // Release and count ch0 up; the first posedge must already count.
        count_enb = 4'b0001;
        updn_cnt  = 4'b0001;
        cycle("release_up_1");
        cycle("up_2");
        cycle("up_3");

        // Asynchronous reset mid-count clears immediately.
        rst_ = 1'b0;
        #2;
        check_reset("reset_async");
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset_held");
        rst_ = 1'b1;
        cycle("post_reset_up");

        // Load beats enable, then holds for five cycles.
        idle();
        ld_cnt[1]    = 1'b0;
        count_enb[1] = 1'b1;
        set_din(1, 16'h0123);
        cycle("load_priority");
        idle();
        for (int k = 0; k < 5; k++) cycle($sformatf("hold_%0d", k));

        // Wrap mode up and down across the bound.
        cnt_max = 16'd9;
        step    = 4'd3;
        ld_cnt[2] = 1'b0;
        set_din(2, 16'd8);
        cycle("wrap_load8");
        idle();
        count_enb[2] = 1'b1;
        updn_cnt[2]  = 1'b1;
        cycle("wrap_up_8to1");
        updn_cnt[2]  = 1'b0;
        cycle("wrap_dn_1to8");

        // Saturate mode.
        idle();
        sat_mode  = 1'b1;
        cnt_max   = 16'd100;
        ld_cnt[3] = 1'b0;
        set_din(3, 16'd98);
        cycle("sat_load98");
        idle();
        step         = 4'd5;
        count_enb[3] = 1'b1;
        updn_cnt[3]  = 1'b1;
        cycle("sat_up_to_max");
        cycle("sat_up_at_max");
        idle();
        ld_cnt[3] = 1'b0;
        set_din(3, 16'd3);
        cycle("sat_load3");
        idle();
        step         = 4'd7;
        count_enb[3] = 1'b1;
        updn_cnt[3]  = 1'b0;
        cycle("sat_dn_to_0");

        // Independent channels in one cycle.
        idle();
        sat_mode = 1'b0;
        cnt_max  = 16'hFFFF;
        step     = 4'd2;
        ld_cnt   = '0;
        for (int i = 0; i < CH; i++) set_din(i, 16'd5);
        cycle("indep_load5");
        idle();
        count_enb = 4'b0011;
        updn_cnt  = 4'b0001;
        ld_cnt[2] = 1'b0;
        set_din(2, 16'h0ABC);
        cycle("indep_mix");

        // Clear colliding with a new wrap event, then a plain clear.
        idle();
        cnt_max   = 16'd9;
        step      = 4'd3;
        ld_cnt[0] = 1'b0;
        set_din(0, 16'd8);
        ovf_clr   = 4'b1110;
        cycle("clr_load8");
        idle();
        count_enb[0] = 1'b1;
        updn_cnt[0]  = 1'b1;
        ovf_clr[0]   = 1'b1;
        cycle("clr_collide");
        idle();
        ovf_clr[0] = 1'b1;
        cycle("clr_plain");

        // Exact hit of the upper bound in wrap mode.
        idle();
        ld_cnt[0] = 1'b0;
        set_din(0, 16'd6);
        cycle("hit_load6");
        idle();
        count_enb[0] = 1'b1;
        updn_cnt[0]  = 1'b1;
        cycle("hit_up_to_max");

        // Step larger than the modulus.
        idle();
        cnt_max   = 16'd2;
        step      = 4'd11;
        ld_cnt[0] = 1'b0;
        set_din(0, 16'd1);
        cycle("bigstep_load1");
        idle();
        count_enb[0] = 1'b1;
        updn_cnt[0]  = 1'b1;
        cycle("bigstep_up");
        updn_cnt[0]  = 1'b0;
        cycle("bigstep_dn");

        // Lowered bound: counting channel clamps first, holding channels keep value.
        idle();
        cnt_max   = 16'hFFFF;
        ld_cnt[1] = 1'b0;
        set_din(1, 16'h0050);
        cycle("clamp_load50");
        idle();
        cnt_max = 16'd9;
        step    = 4'd1;
        cycle("clamp_hold");
        count_enb[1] = 1'b1;
        updn_cnt[1]  = 1'b1;
        cycle("clamp_up_wrap");

        // Zero step counts nothing.
        idle();
        count_enb = '1;
        step      = 4'd0;
        cycle("step0_hold");

        // Randomized mix.
        for (int k = 0; k < 80; k++) begin
            if (k % 8 == 0) begin
                case ($urandom_range(0, 3))
                    0: cnt_max = 16'hFFFF;
                    1: cnt_max = W'($urandom);
                    default: cnt_max = W'($urandom_range(0, 20));
                endcase
            end
            ld_cnt    = ~(CH'($urandom) & CH'($urandom));
            count_enb = CH'($urandom);
            updn_cnt  = CH'($urandom);
            ovf_clr   = CH'($urandom) & CH'($urandom);
            sat_mode  = 1'($urandom);
            step      = SW'($urandom);
            for (int i = 0; i < CH; i++) begin
                set_din(i, (k % 2 == 0) ? W'($urandom) : W'($urandom_range(0, 25)));
            end
            cycle($sformatf("rand_%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
